ram_true_dp_out_reg_param: RTL and testbench

RAM_TRUE_DP_OUT_REG_PARAM -- requirements
Module: ram_true_dp_out_reg_param

---
 rtl/ram_true_dp_out_reg_param.sv | 151 +++++++++++++++
 tb/tb_ram_true_dp_out_reg_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_true_dp_out_reg_param.sv
// True dual-port RAM, byte-lane write enables, selectable read/write behaviour and optional output register.
// Ports: clk, rst_n (sync, active-low); per port X in {A,B}: weX, reX, addrX, dinX, beX in; doutX, validX out.
// collision out: one-cycle pulse after an edge where both ports wrote the same address.
module ram_true_dp_out_reg_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int OUT_REG    = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              weA,
  input  logic              weB,
  input  logic              reA,
  input  logic              reB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dinA,
  input  logic [DATA_W-1:0] dinB,
  input  logic [DATA_W/8-1:0] beA,
  input  logic [DATA_W/8-1:0] beB,
  output logic [DATA_W-1:0] doutA,
  output logic [DATA_W-1:0] doutB,
  output logic              validA,
  output logic              validB,
  output logic              collision
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  // Storage has no reset and no initial contents; it survives rst_n.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_old_a, w_old_b;
  logic [DATA_W-1:0] w_merge_a, w_merge_b;
  logic [DATA_W-1:0] w_s1_nxt_a, w_s1_nxt_b;
  logic              w_s1_vnxt_a, w_s1_vnxt_b;

  logic [DATA_W-1:0] r_s1_dat_a, r_s1_dat_b;
  logic              r_s1_vld_a, r_s1_vld_b;
  logic              r_coll;

  // Pre-edge contents; a read on either port always sees the word before this edge's writes.
  assign w_old_a = r_mem[addrA];
  assign w_old_b = r_mem[addrB];

  // Word as this port alone would leave it (used by write-first).
  always_comb begin
    w_merge_a = w_old_a;
    w_merge_b = w_old_b;
    for (int k = 0; k < NB; k++) begin
      if (beA[k]) w_merge_a[8*k +: 8] = dinA[8*k +: 8];
      if (beB[k]) w_merge_b[8*k +: 8] = dinB[8*k +: 8];
    end
  end

  // Stage-1 next state: holds data on idle edges and on no-change writes.
  always_comb begin
    w_s1_nxt_a  = r_s1_dat_a;
    w_s1_vnxt_a = 1'b0;
    if (weA) begin
      if (WRITE_MODE == 0) begin
        w_s1_nxt_a  = w_old_a;
        w_s1_vnxt_a = 1'b1;
      end else if (WRITE_MODE == 1) begin
        w_s1_nxt_a  = w_merge_a;
        w_s1_vnxt_a = 1'b1;
      end
    end else if (reA) begin
      w_s1_nxt_a  = w_old_a;
      w_s1_vnxt_a = 1'b1;
    end
  end

  always_comb begin
    w_s1_nxt_b  = r_s1_dat_b;
    w_s1_vnxt_b = 1'b0;
    if (weB) begin
      if (WRITE_MODE == 0) begin
        w_s1_nxt_b  = w_old_b;
        w_s1_vnxt_b = 1'b1;
      end else if (WRITE_MODE == 1) begin
        w_s1_nxt_b  = w_merge_b;
        w_s1_vnxt_b = 1'b1;
      end
    end else if (reB) begin
      w_s1_nxt_b  = w_old_b;
      w_s1_vnxt_b = 1'b1;
    end
  end

  // Port A's lane writes are issued after port B's so A wins lanes both enable on a shared address.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NB; k++) begin
        if (weB && beB[k]) r_mem[addrB][8*k +: 8] <= dinB[8*k +: 8];
        if (weA && beA[k]) r_mem[addrA][8*k +: 8] <= dinA[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_dat_a <= '0;
      r_s1_dat_b <= '0;
      r_s1_vld_a <= 1'b0;
      r_s1_vld_b <= 1'b0;
      r_coll     <= 1'b0;
    end else begin
      r_s1_dat_a <= w_s1_nxt_a;
      r_s1_dat_b <= w_s1_nxt_b;
      r_s1_vld_a <= w_s1_vnxt_a;
      r_s1_vld_b <= w_s1_vnxt_b;
      r_coll     <= weA & weB & (addrA == addrB);
    end
  end

  // Collision is single-stage regardless of the output register.
  assign collision = r_coll;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_out_a, r_out_b;
    logic              r_out_vld_a, r_out_vld_b;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out_a     <= '0;
        r_out_b     <= '0;
        r_out_vld_a <= 1'b0;
        r_out_vld_b <= 1'b0;
      end else begin
        r_out_a     <= r_s1_dat_a;
        r_out_b     <= r_s1_dat_b;
        r_out_vld_a <= r_s1_vld_a;
        r_out_vld_b <= r_s1_vld_b;
      end
    end

    assign doutA  = r_out_a;
    assign doutB  = r_out_b;
    assign validA = r_out_vld_a;
    assign validB = r_out_vld_b;
  end else begin : g_noreg
    assign doutA  = r_s1_dat_a;
    assign doutB  = r_s1_dat_b;
    assign validA = r_s1_vld_a;
    assign validB = r_s1_vld_b;
  end

endmodule

// File: tb/tb_ram_true_dp_out_reg_param.sv
module tb_ram_true_dp_out_reg_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        weA, weB, reA, reB;
  logic [8:0]  addrA, addrB;
  logic [15:0] dinA, dinB;
  logic [1:0]  beA, beB;

  // Instances: 0 = OUT_REG1/read-first, 1 = OUT_REG1/write-first, 2 = OUT_REG1/no-change, 3 = OUT_REG0/read-first
  logic [15:0] doutA_w [4];
  logic [15:0] doutB_w [4];
  logic        validA_w [4];
  logic        validB_w [4];
  logic        coll_w [4];

  always #5 clk = ~clk;

  ram_true_dp_out_reg_param #(.DATA_W(16), .ADDR_W(9), .OUT_REG(1), .WRITE_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB), .beA(beA), .beB(beB),
    .doutA(doutA_w[0]), .doutB(doutB_w[0]), .validA(validA_w[0]), .validB(validB_w[0]),
    .collision(coll_w[0]));

  ram_true_dp_out_reg_param #(.DATA_W(16), .ADDR_W(9), .OUT_REG(1), .WRITE_MODE(1)) dut_wf (
    .clk(clk), .rst_n(rst_n), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB), .beA(beA), .beB(beB),
    .doutA(doutA_w[1]), .doutB(doutB_w[1]), .validA(validA_w[1]), .validB(validB_w[1]),
    .collision(coll_w[1]));

  ram_true_dp_out_reg_param #(.DATA_W(16), .ADDR_W(9), .OUT_REG(1), .WRITE_MODE(2)) dut_nc (
    .clk(clk), .rst_n(rst_n), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB), .beA(beA), .beB(beB),
    .doutA(doutA_w[2]), .doutB(doutB_w[2]), .validA(validA_w[2]), .validB(validB_w[2]),
    .collision(coll_w[2]));

  ram_true_dp_out_reg_param #(.DATA_W(16), .ADDR_W(9), .OUT_REG(0), .WRITE_MODE(0)) dut_or0 (
    .clk(clk), .rst_n(rst_n), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB), .beA(beA), .beB(beB),
    .doutA(doutA_w[3]), .doutB(doutB_w[3]), .validA(validA_w[3]), .validB(validB_w[3]),
    .collision(coll_w[3]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference memory and expected one-edge (OUT_REG=0, read-first) port results.
  logic [15:0] mdl [512];
  logic [15:0] exp_a, exp_b;
  logic        ev_a, ev_b, ec;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] w;
    w = old;
    if (be[0]) w[7:0]  = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    return w;
  endfunction

  task automatic idle();
    weA = 0; weB = 0; reA = 0; reB = 0;
    addrA = '0; addrB = '0; dinA = '0; dinB = '0; beA = '0; beB = '0;
  endtask

  // Predict the outcome of the coming edge from current inputs, then advance one edge.
  task automatic cycle();
    if (!rst_n) begin
      ev_a = 0; ev_b = 0; exp_a = '0; exp_b = '0; ec = 0;
    end else begin
      ev_a = reA | weA;
      ev_b = reB | weB;
      if (ev_a) exp_a = mdl[addrA];
      if (ev_b) exp_b = mdl[addrB];
      ec = weA & weB & (addrA == addrB);
      if (weB) mdl[addrB] = merge(mdl[addrB], dinB, beB);
      if (weA) mdl[addrA] = merge(mdl[addrA], dinA, beA);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
    idle(); weA = 1; addrA = a; dinA = d; beA = be; cycle(); idle();
  endtask

  task automatic rd_a(input logic [8:0] a);
    idle(); reA = 1; addrA = a; cycle(); idle(); cycle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_doutA%0d", i), 32'(doutA_w[i]), 32'h0);
      check($sformatf("rst_doutB%0d", i), 32'(doutB_w[i]), 32'h0);
      check($sformatf("rst_validA%0d", i), 32'(validA_w[i]), 32'h0);
      check($sformatf("rst_validB%0d", i), 32'(validB_w[i]), 32'h0);
      check($sformatf("rst_coll%0d", i), 32'(coll_w[i]), 32'h0);
    end
    rst_n = 1;
    cycle();

    // Write on A, read on B: two-edge latency with OUT_REG=1, one edge with OUT_REG=0.
    wr_a(9'h010, 16'hBEEF, 2'b11);
    idle(); reB = 1; addrB = 9'h010; cycle(); idle();
    check("rdB_or1_early_valid", 32'(validB_w[0]), 32'h0);
    check("rdB_or0_dout", 32'(doutB_w[3]), 32'hBEEF);
    check("rdB_or0_valid", 32'(validB_w[3]), 32'h1);
    cycle();
    check("rdB_or1_dout", 32'(doutB_w[0]), 32'hBEEF);
    check("rdB_or1_valid", 32'(validB_w[0]), 32'h1);

    // Same-address double write: A wins shared lanes.
    idle(); weA = 1; weB = 1; addrA = 9'h1FF; addrB = 9'h1FF;
    dinA = 16'h1234; beA = 2'b01; dinB = 16'hABCD; beB = 2'b11;
    cycle(); idle();
    check("coll_or1", 32'(coll_w[0]), 32'h1);
    check("coll_or0", 32'(coll_w[3]), 32'h1);
    cycle();
    check("coll_one_cycle", 32'(coll_w[0]), 32'h0);
    rd_a(9'h1FF);
    check("coll_word_01_11", 32'(doutA_w[0]), 32'hAB34);
    idle(); weA = 1; weB = 1; addrA = 9'h1FF; addrB = 9'h1FF;
    dinA = 16'h1234; beA = 2'b11; dinB = 16'hABCD; beB = 2'b11;
    cycle(); idle();
    check("coll2_flag", 32'(coll_w[0]), 32'h1);
    rd_a(9'h1FF);
    check("coll_word_11_11", 32'(doutA_w[0]), 32'h1234);

    // Write-mode behaviour on a write with read enable.
    wr_a(9'h005, 16'h0000, 2'b11);
    idle(); reA = 1; addrA = 9'h010; cycle();
    idle(); weA = 1; reA = 1; addrA = 9'h005; dinA = 16'h5A5A; beA = 2'b11; cycle();
    idle(); cycle();
    check("wm0_dout", 32'(doutA_w[0]), 32'h0000);
    check("wm0_valid", 32'(validA_w[0]), 32'h1);
    check("wm1_dout", 32'(doutA_w[1]), 32'h5A5A);
    check("wm1_valid", 32'(validA_w[1]), 32'h1);
    check("wm2_dout", 32'(doutA_w[2]), 32'hBEEF);
    check("wm2_valid", 32'(validA_w[2]), 32'h0);

    // Cross-port read during write: old word, no collision.
    wr_a(9'h020, 16'h1111, 2'b11);
    idle(); weB = 1; addrB = 9'h020; dinB = 16'h00FF; beB = 2'b11; reA = 1; addrA = 9'h020;
    cycle(); idle();
    check("xrd_coll", 32'(coll_w[0]), 32'h0);
    check("xrd_or0_old", 32'(doutA_w[3]), 32'h1111);
    cycle();
    check("xrd_or1_old", 32'(doutA_w[0]), 32'h1111);
    rd_a(9'h020);
    check("xrd_new", 32'(doutA_w[0]), 32'h00FF);

    // Reset while a read is in flight; a write attempted during reset must not land.
    idle(); reA = 1; addrA = 9'h010; cycle();
    rst_n = 0; idle(); weA = 1; addrA = 9'h010; dinA = 16'h0000; beA = 2'b11; cycle();
    rst_n = 1; idle();
    check("inflight_dout", 32'(doutA_w[0]), 32'h0);
    check("inflight_valid", 32'(validA_w[0]), 32'h0);
    cycle();
    check("after_rel_valid", 32'(validA_w[0]), 32'h0);
    rd_a(9'h010);
    check("retained_word", 32'(doutA_w[0]), 32'hBEEF);
    check("retained_valid", 32'(validA_w[0]), 32'h1);

    // Fill every word, then random dual-port traffic checked on the OUT_REG=0 instance.
    for (int i = 0; i < 512; i++) begin
      idle(); weA = 1; addrA = 9'(i); dinA = 16'($urandom); beA = 2'b11; cycle();
    end
    for (int n = 0; n < 2000; n++) begin
      weA = 1'($urandom_range(0, 2) == 0); reA = 1'($urandom);
      weB = 1'($urandom_range(0, 2) == 0); reB = 1'($urandom);
      addrA = 9'($urandom);
      addrB = ($urandom_range(0, 3) == 0) ? addrA : 9'($urandom);
      dinA = 16'($urandom); dinB = 16'($urandom);
      beA = 2'($urandom); beB = 2'($urandom);
      cycle();
      check("rnd_validA", 32'(validA_w[3]), 32'(ev_a));
      check("rnd_validB", 32'(validB_w[3]), 32'(ev_b));
      if (ev_a) check("rnd_doutA", 32'(doutA_w[3]), 32'(exp_a));
      if (ev_b) check("rnd_doutB", 32'(doutB_w[3]), 32'(exp_b));
      check("rnd_coll", 32'(coll_w[3]), 32'(ec));
    end
    idle();
    // Final sweep: stored words after random traffic.
    for (int i = 0; i < 512; i += 37) begin
      idle(); reB = 1; addrB = 9'(i); cycle();
      check("sweep_word", 32'(doutB_w[3]), 32'(mdl[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
